// File: rtl/pipe_mux_sel_pkg.sv
// Shared types for the pipelined operand selector: occupancy encoding and
// default geometry used when the block is instantiated without overrides.
package pipe_mux_pkg;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefNumIn    = 8;
  localparam int unsigned DefNumLegal = 6;

  typedef enum logic [1:0] {
    OccEmpty,
    OccOne,
    OccFull
  } occ_e;

endpackage

// File: rtl/pipe_mux_sel_if.sv
// Handshake bundle for pipe_mux_sel: upstream data/select, downstream
// selected item, and the sticky error controls.
interface pipe_mux_sel_if #(
  parameter int unsigned WIDTH  = pipe_mux_pkg::DefWidth,
  parameter int unsigned NUM_IN = pipe_mux_pkg::DefNumIn
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_clr;
  logic                    err_sticky;

  modport master (
    output in_data, in_sel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_sel, out_err, out_valid, err_sticky
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_sel, out_err, out_valid, err_sticky
  );

endinterface

// File: rtl/mux_sel_comb.sv
// Combinational N-way select with legality check; illegal selects yield
// DEFAULT_VAL and assert err.
module mux_sel_comb #(
  parameter int unsigned     WIDTH       = 16,
  parameter int unsigned     NUM_IN      = 8,
  parameter int unsigned     NUM_LEGAL   = 6,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int unsigned    SEL_W       = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        y,
  output logic                    err
);

  always_comb begin
    y   = DEFAULT_VAL;
    err = (32'(sel) >= NUM_LEGAL);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k) && k < NUM_LEGAL) begin
        y = data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pipe_mux_sel.sv
// Registered N-way selector with valid/ready on both sides; a main register
// drives the outputs and one skid register absorbs a single stalled accept.
module pipe_mux_sel
  import pipe_mux_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      NUM_IN      = 8,
  parameter int unsigned      NUM_LEGAL   = 6,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int unsigned     SEL_W       = $clog2(NUM_IN)
) (
  input logic           clk,
  input logic           reset,
  pipe_mux_sel_if.slave bus
);

  // Widths follow the instance parameters, so the entry type lives here.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } entry_t;

  occ_e             state_q;
  entry_t           main_q, skid_q, new_e;
  logic             out_valid_q, in_ready_q, err_sticky_q;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept, emit;

  mux_sel_comb #(
    .WIDTH      (WIDTH),
    .NUM_IN     (NUM_IN),
    .NUM_LEGAL  (NUM_LEGAL),
    .DEFAULT_VAL(DEFAULT_VAL)
  ) u_mux (
    .data(bus.in_data),
    .sel (bus.in_sel),
    .y   (sel_data),
    .err (sel_err)
  );

  assign new_e  = '{data: sel_data, sel: bus.in_sel, err: sel_err};
  assign accept = bus.in_valid && in_ready_q;
  assign emit   = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= OccEmpty;
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      err_sticky_q <= 1'b0;
    end else begin
      unique case (state_q)
        OccEmpty: begin
          if (accept) begin
            main_q      <= new_e;
            out_valid_q <= 1'b1;
            state_q     <= OccOne;
          end
        end
        OccOne: begin
          if (accept && emit) begin
            main_q <= new_e;
          end else if (accept) begin
            skid_q     <= new_e;
            in_ready_q <= 1'b0;
            state_q    <= OccFull;
          end else if (emit) begin
            out_valid_q <= 1'b0;
            state_q     <= OccEmpty;
          end
        end
        OccFull: begin
          // in_ready is low here, so only the drain side can move.
          if (emit) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= OccOne;
          end
        end
        default: state_q <= OccEmpty;
      endcase

      if (accept && new_e.err) begin
        err_sticky_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = main_q.data;
  assign bus.out_sel    = main_q.sel;
  assign bus.out_err    = main_q.err;
  assign bus.err_sticky = err_sticky_q;

endmodule
